// File: rtl/cavlc_bitstream_shifter.sv
// CAVLC bitstream shifter: 64-bit left-justified bit buffer fed by 32-bit words,
// presenting the next 16 unconsumed bits to the coeff-token decoder.
module cavlc_bitstream_shifter (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Flush,
  input  logic [31:0] InData,
  input  logic        InValid,
  output logic        InReady,
  input  logic        Consume,
  input  logic [4:0]  ShiftAmt,
  output logic [15:0] BitsOut,
  output logic        BitsValid,
  output logic [6:0]  FillLevel,
  output logic [31:0] BitPos,
  output logic        ShiftErr
);

  logic [63:0] bufR;
  logic [6:0]  fillR;
  logic [31:0] bitPosR;
  logic        shiftErrR;
  logic        validR;
  logic        readyR;

  logic [4:0]  effAmtS;
  logic        consumeOkS;
  logic        acceptS;
  logic [63:0] shiftedS;
  logic [6:0]  fillAfterS;
  logic [63:0] bufNextS;
  logic [6:0]  fillNextS;
  logic [31:0] bitPosNextS;
  logic        shiftErrNextS;

  // Next-state: shift out consumed bits first, then append the new word at the post-shift fill.
  always_comb begin
    effAmtS       = 5'd0;
    consumeOkS    = Consume && validR && !Flush;
    acceptS       = InValid && readyR && !Flush;
    shiftedS      = bufR;
    fillAfterS    = fillR;
    bufNextS      = bufR;
    fillNextS     = fillR;
    bitPosNextS   = bitPosR;
    shiftErrNextS = shiftErrR;

    if (ShiftAmt > 5'd16) begin
      effAmtS = 5'd16;
    end else begin
      effAmtS = ShiftAmt;
    end

    if (consumeOkS) begin
      shiftedS      = bufR << effAmtS;
      fillAfterS    = fillR - {2'd0, effAmtS};
      bitPosNextS   = bitPosR + {27'd0, effAmtS};
      shiftErrNextS = shiftErrR | (ShiftAmt > 5'd16);
    end else begin
      shiftedS   = bufR;
      fillAfterS = fillR;
    end

    // Append is only possible at fill <= 32, so the word always fits below the held bits.
    if (acceptS) begin
      bufNextS  = shiftedS | ({InData, 32'd0} >> fillAfterS);
      fillNextS = fillAfterS + 7'd32;
    end else begin
      bufNextS  = shiftedS;
      fillNextS = fillAfterS;
    end

    if (Flush) begin
      bufNextS      = 64'd0;
      fillNextS     = 7'd0;
      bitPosNextS   = 32'd0;
      shiftErrNextS = 1'b0;
    end else begin
      shiftErrNextS = shiftErrNextS;
    end
  end

  // State register; handshake flags are registered alongside the fill they derive from.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      bufR      <= 64'd0;
      fillR     <= 7'd0;
      bitPosR   <= 32'd0;
      shiftErrR <= 1'b0;
      validR    <= 1'b0;
      readyR    <= 1'b1;
    end else begin
      bufR      <= bufNextS;
      fillR     <= fillNextS;
      bitPosR   <= bitPosNextS;
      shiftErrR <= shiftErrNextS;
      validR    <= (fillNextS >= 7'd16);
      readyR    <= (fillNextS <= 7'd32);
    end
  end

  assign BitsOut   = bufR[63:48];
  assign BitsValid = validR;
  assign InReady   = readyR;
  assign FillLevel = fillR;
  assign BitPos    = bitPosR;
  assign ShiftErr  = shiftErrR;

endmodule

// File: tb/tb_cavlc_bitstream_shifter.sv
// Directed bench for cavlc_bitstream_shifter plus a queue-model pseudo-random stream.
module tb_cavlc_bitstream_shifter;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        Flush;
  logic [31:0] InData;
  logic        InValid;
  logic        InReady;
  logic        Consume;
  logic [4:0]  ShiftAmt;
  logic [15:0] BitsOut;
  logic        BitsValid;
  logic [6:0]  FillLevel;
  logic [31:0] BitPos;
  logic        ShiftErr;

  int nCompared = 0;
  int nMismatched = 0;

  cavlc_bitstream_shifter dut (
    .Clk(Clk), .nReset(nReset), .Flush(Flush), .InData(InData), .InValid(InValid),
    .InReady(InReady), .Consume(Consume), .ShiftAmt(ShiftAmt), .BitsOut(BitsOut),
    .BitsValid(BitsValid), .FillLevel(FillLevel), .BitPos(BitPos), .ShiftErr(ShiftErr)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Flush = 1'b0; InValid = 1'b0; Consume = 1'b0; ShiftAmt = 5'd0; InData = 32'd0;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    idle();
    #12;
    nCompared++;
    if (BitsOut !== 16'h0000 || BitsValid !== 1'b0 || InReady !== 1'b1 ||
        FillLevel !== 7'd0 || BitPos !== 32'd0 || ShiftErr !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset: out=%h valid=%b ready=%b fill=%0d pos=%0d err=%b, want 0000 0 1 0 0 0",
               BitsOut, BitsValid, InReady, FillLevel, BitPos, ShiftErr);
    end
    nReset = 1'b1;
  endtask

  task automatic test_push();
    InData = 32'hA5A5F00F; InValid = 1'b1;
    step();
    idle();
    nCompared++;
    if (BitsOut !== 16'hA5A5 || FillLevel !== 7'd32 || BitsValid !== 1'b1 || InReady !== 1'b1) begin
      nMismatched++;
      $display("FAIL push: out=%h fill=%0d valid=%b ready=%b, want a5a5 32 1 1",
               BitsOut, FillLevel, BitsValid, InReady);
    end
  endtask

  task automatic test_consume();
    Consume = 1'b1; ShiftAmt = 5'd4;
    step();
    idle();
    nCompared++;
    if (BitsOut !== 16'h5A5F || FillLevel !== 7'd28 || BitPos !== 32'd4) begin
      nMismatched++;
      $display("FAIL consume4: out=%h fill=%0d pos=%0d, want 5a5f 28 4", BitsOut, FillLevel, BitPos);
    end
  endtask

  task automatic test_back_to_back();
    InData = 32'h12345678; InValid = 1'b1; Consume = 1'b1; ShiftAmt = 5'd12;
    step();
    idle();
    nCompared++;
    if (BitsOut !== 16'hF00F || FillLevel !== 7'd48 || BitPos !== 32'd16) begin
      nMismatched++;
      $display("FAIL pushconsume: out=%h fill=%0d pos=%0d, want f00f 48 16", BitsOut, FillLevel, BitPos);
    end
    Consume = 1'b1; ShiftAmt = 5'd16;
    step();
    idle();
    nCompared++;
    if (BitsOut !== 16'h1234 || FillLevel !== 7'd32 || BitPos !== 32'd32) begin
      nMismatched++;
      $display("FAIL following16: out=%h fill=%0d pos=%0d, want 1234 32 32", BitsOut, FillLevel, BitPos);
    end
  endtask

  task automatic test_full();
    InData = 32'hDEADBEEF; InValid = 1'b1;
    step();
    nCompared++;
    if (FillLevel !== 7'd64 || InReady !== 1'b0 || BitsOut !== 16'h1234) begin
      nMismatched++;
      $display("FAIL full: fill=%0d ready=%b out=%h, want 64 0 1234", FillLevel, InReady, BitsOut);
    end
    InData = 32'hCAFEF00D;
    step();
    step();
    nCompared++;
    if (FillLevel !== 7'd64 || BitsOut !== 16'h1234) begin
      nMismatched++;
      $display("FAIL fullhold: fill=%0d out=%h, want 64 1234", FillLevel, BitsOut);
    end
    Consume = 1'b1; ShiftAmt = 5'd16;
    step();
    nCompared++;
    if (FillLevel !== 7'd48 || InReady !== 1'b0 || BitsOut !== 16'h5678) begin
      nMismatched++;
      $display("FAIL full48: fill=%0d ready=%b out=%h, want 48 0 5678", FillLevel, InReady, BitsOut);
    end
    step();
    Consume = 1'b0;
    nCompared++;
    if (FillLevel !== 7'd32 || InReady !== 1'b1 || BitsOut !== 16'hDEAD) begin
      nMismatched++;
      $display("FAIL full32: fill=%0d ready=%b out=%h, want 32 1 dead", FillLevel, InReady, BitsOut);
    end
    step();
    idle();
    nCompared++;
    if (FillLevel !== 7'd64 || BitsOut !== 16'hDEAD || BitPos !== 32'd64) begin
      nMismatched++;
      $display("FAIL refill: fill=%0d out=%h pos=%0d, want 64 dead 64", FillLevel, BitsOut, BitPos);
    end
  endtask

  task automatic test_shift_err();
    Consume = 1'b1; ShiftAmt = 5'd16;
    step();
    step();
    idle();
    nCompared++;
    if (FillLevel !== 7'd32 || BitsOut !== 16'hCAFE || BitPos !== 32'd96 || ShiftErr !== 1'b0) begin
      nMismatched++;
      $display("FAIL pre_err: fill=%0d out=%h pos=%0d err=%b, want 32 cafe 96 0",
               FillLevel, BitsOut, BitPos, ShiftErr);
    end
    Consume = 1'b1; ShiftAmt = 5'd20;
    step();
    idle();
    nCompared++;
    if (FillLevel !== 7'd16 || BitsOut !== 16'hF00D || BitPos !== 32'd112 || ShiftErr !== 1'b1) begin
      nMismatched++;
      $display("FAIL shift20: fill=%0d out=%h pos=%0d err=%b, want 16 f00d 112 1",
               FillLevel, BitsOut, BitPos, ShiftErr);
    end
    Consume = 1'b1; ShiftAmt = 5'd0;
    step();
    idle();
    nCompared++;
    if (FillLevel !== 7'd16 || BitsOut !== 16'hF00D || BitPos !== 32'd112 || ShiftErr !== 1'b1) begin
      nMismatched++;
      $display("FAIL shift0_sticky: fill=%0d out=%h pos=%0d err=%b, want 16 f00d 112 1",
               FillLevel, BitsOut, BitPos, ShiftErr);
    end
    Flush = 1'b1; InValid = 1'b1; InData = 32'hFFFFFFFF; Consume = 1'b1; ShiftAmt = 5'd8;
    step();
    idle();
    nCompared++;
    if (FillLevel !== 7'd0 || BitPos !== 32'd0 || ShiftErr !== 1'b0 || BitsValid !== 1'b0 ||
        BitsOut !== 16'h0000 || InReady !== 1'b1) begin
      nMismatched++;
      $display("FAIL flush: fill=%0d pos=%0d err=%b valid=%b out=%h ready=%b, want 0 0 0 0 0000 1",
               FillLevel, BitPos, ShiftErr, BitsValid, BitsOut, InReady);
    end
  endtask

  task automatic test_ignored_consume();
    Consume = 1'b1; ShiftAmt = 5'd5;
    step();
    idle();
    nCompared++;
    if (FillLevel !== 7'd0 || BitPos !== 32'd0 || BitsOut !== 16'h0000) begin
      nMismatched++;
      $display("FAIL ignored_consume: fill=%0d pos=%0d out=%h, want 0 0 0000", FillLevel, BitPos, BitsOut);
    end
  endtask

  task automatic test_async_reset();
    InData = 32'h87654321; InValid = 1'b1;
    step();
    idle();
    #2;
    nReset = 1'b0;
    #1;
    nCompared++;
    if (FillLevel !== 7'd0 || BitsOut !== 16'h0000 || InReady !== 1'b1 || BitsValid !== 1'b0) begin
      nMismatched++;
      $display("FAIL async_reset: fill=%0d out=%h ready=%b valid=%b, want 0 0000 1 0",
               FillLevel, BitsOut, InReady, BitsValid);
    end
    #2;
    nReset = 1'b1;
    step();
    nCompared++;
    if (FillLevel !== 7'd0 || BitPos !== 32'd0) begin
      nMismatched++;
      $display("FAIL post_reset: fill=%0d pos=%0d, want 0 0", FillLevel, BitPos);
    end
  endtask

  // Bit-level queue model: every consumed bit must come out in the order it was pushed.
  task automatic test_stream();
    bit          q[$];
    logic [15:0] expOut;
    logic [31:0] word;
    int unsigned total = 0;
    int          errs = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < 16; i++) expOut[15-i] = (i < q.size()) ? q[i] : 1'b0;
      if (FillLevel !== 7'(q.size()) || BitsOut !== expOut ||
          BitsValid !== (q.size() >= 16) || InReady !== (q.size() <= 32)) begin
        errs++;
        if (errs <= 5)
          $display("FAIL stream cyc %0d: fill=%0d out=%h valid=%b ready=%b, want %0d %h %b %b",
                   cyc, FillLevel, BitsOut, BitsValid, InReady, q.size(), expOut,
                   q.size() >= 16, q.size() <= 32);
      end
      word     = $urandom;
      InData   = word;
      InValid  = ($urandom_range(0, 3) != 0);
      Consume  = ($urandom_range(0, 3) != 0);
      ShiftAmt = 5'($urandom_range(0, 16));
      begin
        bool_model_update(q, total, word);
      end
      step();
    end
    idle();
    nCompared++;
    if (errs != 0) begin
      nMismatched++;
      $display("FAIL stream: %0d bad cycles, want 0", errs);
    end
    nCompared++;
    if (BitPos !== total) begin
      nMismatched++;
      $display("FAIL stream_bitpos: pos=%0d, want %0d", BitPos, total);
    end
  endtask

  task automatic bool_model_update(inout bit q[$], inout int unsigned total, input logic [31:0] word);
    bit readyBefore;
    readyBefore = (q.size() <= 32);
    if (Consume && q.size() >= 16) begin
      for (int i = 0; i < int'(ShiftAmt); i++) void'(q.pop_front());
      total += ShiftAmt;
    end
    if (InValid && readyBefore) begin
      for (int i = 31; i >= 0; i--) q.push_back(word[i]);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_consume();
    test_back_to_back();
    test_full();
    test_shift_err();
    test_ignored_consume();
    test_async_reset();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
